// File: rtl/agc_uplink_tx_if.sv
// Uplink transmitter bus: word handshake, inhibit, and the two pulse lines.
interface agc_uplink_tx_if #(
    parameter int unsigned WORD_W = 15
);
    logic [WORD_W-1:0] word;
    logic              valid;
    logic              ready;
    logic              inh;
    logic              upl0;
    logic              upl1;
    logic              busy;
    logic              done;

    // Source side: supplies words and inhibit, observes pulses and status.
    modport master (
        output word, valid, inh,
        input  ready, upl0, upl1, busy, done
    );

    // Transmitter side.
    modport slave (
        input  word, valid, inh,
        output ready, upl0, upl1, busy, done
    );
endinterface

// File: rtl/agc_uplink_tx.sv
// AGC ground uplink transmitter: serialises one word MSB first as pulses on
// upl1 (one bits) and upl0 (zero bits), each pulse followed by a quiet gap.
// Optional build macro AGC_UPLINK_PARITY_EN appends an odd-parity pulse.
module agc_uplink_tx #(
    parameter int unsigned WORD_W    = 15,
    parameter int unsigned PULSE_CYC = 4,
    parameter int unsigned GAP_CYC   = 12
) (
    input  logic          clk,
    input  logic          rst,
    agc_uplink_tx_if.slave bus
);

`ifdef AGC_UPLINK_PARITY_EN
    localparam int unsigned TOTAL_W = WORD_W + 1;
`else
    localparam int unsigned TOTAL_W = WORD_W;
`endif
    localparam int unsigned CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned BIT_W   = $clog2(TOTAL_W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t               state_q, state_nx;
    logic [TOTAL_W-1:0]   sreg_q, sreg_nx;
    logic [CNT_W-1:0]     cnt_q, cnt_nx;
    logic [BIT_W-1:0]     bits_q, bits_nx;
    logic [TOTAL_W-1:0]   load_word;
    logic                 done_nx;

    logic                 upl0_q, upl1_q, ready_q, busy_q, done_q;
    logic                 upl0_nx, upl1_nx, ready_nx, busy_nx;

    // Word as it enters the shift register, with parity bit in the LSB when enabled.
`ifdef AGC_UPLINK_PARITY_EN
    assign load_word = {bus.word, ~^bus.word};
`else
    assign load_word = bus.word;
`endif

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            bits_q  <= '0;
            upl0_q  <= 1'b0;
            upl1_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nx;
            sreg_q  <= sreg_nx;
            cnt_q   <= cnt_nx;
            bits_q  <= bits_nx;
            upl0_q  <= upl0_nx;
            upl1_q  <= upl1_nx;
            ready_q <= ready_nx;
            busy_q  <= busy_nx;
            done_q  <= done_nx;
        end
    end

    // Next state: pulse/gap timing, bit sequencing and inhibit hold-off.
    always_comb begin
        state_nx = state_q;
        sreg_nx  = sreg_q;
        cnt_nx   = cnt_q;
        bits_nx  = bits_q;
        done_nx  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.valid) begin
                    sreg_nx = load_word;
                    bits_nx = BIT_W'(TOTAL_W);
                    if (!bus.inh) begin
                        state_nx = S_PULSE;
                        cnt_nx   = CNT_W'(PULSE_CYC - 1);
                    end else begin
                        // Parked at an expired gap until inhibit clears.
                        state_nx = S_GAP;
                        cnt_nx   = '0;
                    end
                end
            end
            S_PULSE: begin
                // inh deliberately ignored here so pulses keep full width.
                if (cnt_q == '0) begin
                    state_nx = S_GAP;
                    cnt_nx   = CNT_W'(GAP_CYC - 1);
                    sreg_nx  = sreg_q << 1;
                    bits_nx  = bits_q - BIT_W'(1);
                end else begin
                    cnt_nx = cnt_q - CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q != '0) begin
                    cnt_nx = cnt_q - CNT_W'(1);
                end else if (bits_q == '0) begin
                    state_nx = S_IDLE;
                    done_nx  = 1'b1;
                end else if (!bus.inh) begin
                    state_nx = S_PULSE;
                    cnt_nx   = CNT_W'(PULSE_CYC - 1);
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output comes from a flop.
    always_comb begin
        upl0_nx  = 1'b0;
        upl1_nx  = 1'b0;
        ready_nx = 1'b0;
        busy_nx  = 1'b0;
        if (state_nx == S_PULSE) begin
            upl1_nx = sreg_nx[TOTAL_W-1];
            upl0_nx = ~sreg_nx[TOTAL_W-1];
        end
        if (state_nx == S_IDLE) begin
            ready_nx = 1'b1;
        end else begin
            busy_nx = 1'b1;
        end
    end

    assign bus.upl0  = upl0_q;
    assign bus.upl1  = upl1_q;
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule
